memcache_key_packer: RTL and testbench



---
 rtl/memcache_key_packer.sv | 178 +++++++++++++++++
 tb/tb_memcache_key_packer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcache_key_packer.sv
// Packs a memcache key, one byte per cycle, into 12-byte blocks (k0,k1,k2) for the hash core.
// Optional length check: define KEY_PACKER_LEN_CHECK_EN to reject keys longer than MAX_KEY_LEN.
//
// state | meaning
// IDLE  | waiting for start; only state that accepts a new key
// FILL  | collecting key bytes into the fill buffer, handing complete blocks to the output register
// DRAIN | last block sits in the output register until the hash core takes it
module memcache_key_packer #(
  parameter int MAX_KEY_LEN = 250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  key_length,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_k0,
  output logic [31:0] out_k1,
  output logic [31:0] out_k2,
  output logic [3:0]  out_nbytes,
  output logic        out_first,
  output logic        out_last,
  output logic [7:0]  out_key_length,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

`ifdef KEY_PACKER_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif
  localparam logic [7:0] LEN_LIMIT = 8'(MAX_KEY_LEN);

  state_t       state, state_nxt;
  logic [95:0]  fill_buf, fill_nxt, wr_buf, load_buf, out_buf;
  logic [3:0]   fill_cnt, cnt_nxt, load_cnt;
  logic [7:0]   remaining, rem_nxt;
  logic         first_flag, first_nxt;
  logic         load, load_first, load_last;
  logic         out_free, fill_cmp, hs, len_bad, start_ok;

  assign len_bad  = LEN_CHECK && (key_length > LEN_LIMIT);
  assign start_ok = start && (state == IDLE) && !len_bad;
  assign out_free = !out_valid || out_ready;
  assign fill_cmp = (fill_cnt == 4'd12) || (remaining == 8'd0);
  // A full buffer may still take a byte when it is moving out this very cycle.
  assign in_ready = (state == FILL) && (remaining != 8'd0) &&
                    ((fill_cnt != 4'd12) || out_free);
  assign hs       = in_valid && in_ready;
  assign busy     = (state != IDLE);

  assign out_k0 = out_buf[95:64];
  assign out_k1 = out_buf[63:32];
  assign out_k2 = out_buf[31:0];

  always_comb begin
    wr_buf = fill_buf;
    for (int i = 0; i < 12; i++) begin
      if (fill_cnt == 4'(i)) wr_buf[95-8*i -: 8] = in_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill_buf;
    cnt_nxt    = fill_cnt;
    rem_nxt    = remaining;
    first_nxt  = first_flag;
    load       = 1'b0;
    load_buf   = fill_buf;
    load_cnt   = fill_cnt;
    load_first = first_flag;
    load_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          rem_nxt   = key_length;
          first_nxt = 1'b1;
          fill_nxt  = '0;
          cnt_nxt   = 4'd0;
          if (key_length == 8'd0) begin
            load       = 1'b1;
            load_buf   = '0;
            load_cnt   = 4'd0;
            load_first = 1'b1;
            load_last  = 1'b1;
            first_nxt  = 1'b0;
            state_nxt  = DRAIN;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (fill_cmp) begin
          if (out_free) begin
            load      = 1'b1;
            load_last = (remaining == 8'd0);
            first_nxt = 1'b0;
            if (remaining == 8'd0) state_nxt = DRAIN;
            if (hs) begin
              fill_nxt = {in_data, 88'd0};
              cnt_nxt  = 4'd1;
              rem_nxt  = remaining - 8'd1;
            end else begin
              fill_nxt = '0;
              cnt_nxt  = 4'd0;
            end
          end
        end else if (hs) begin
          rem_nxt = remaining - 8'd1;
          cnt_nxt = fill_cnt + 4'd1;
          // Completing byte goes straight to a free output register, saving a cycle.
          if (((fill_cnt == 4'd11) || (remaining == 8'd1)) && out_free) begin
            load      = 1'b1;
            load_buf  = wr_buf;
            load_cnt  = fill_cnt + 4'd1;
            load_last = (remaining == 8'd1);
            first_nxt = 1'b0;
            fill_nxt  = '0;
            cnt_nxt   = 4'd0;
            if (remaining == 8'd1) state_nxt = DRAIN;
          end else begin
            fill_nxt = wr_buf;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_buf       <= '0;
      fill_cnt       <= 4'd0;
      remaining      <= 8'd0;
      first_flag     <= 1'b0;
      out_valid      <= 1'b0;
      out_buf        <= '0;
      out_nbytes     <= 4'd0;
      out_first      <= 1'b0;
      out_last       <= 1'b0;
      out_key_length <= 8'd0;
      err            <= 1'b0;
    end else begin
      fill_buf   <= fill_nxt;
      fill_cnt   <= cnt_nxt;
      remaining  <= rem_nxt;
      first_flag <= first_nxt;
      err        <= start && (state == IDLE) && len_bad;
      if (start_ok) out_key_length <= key_length;
      if (load) begin
        out_valid  <= 1'b1;
        out_buf    <= load_buf;
        out_nbytes <= load_cnt;
        out_first  <= load_first;
        out_last   <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memcache_key_packer.sv
// Self-checking bench for memcache_key_packer: randomized keys and handshakes against a block-chunking model.
module tb_memcache_key_packer;
  logic        CLK = 1'b0;
  logic        RST, start, in_valid, out_ready;
  logic [7:0]  key_length, in_data;
  logic        busy, in_ready, out_valid, out_first, out_last, err;
  logic [31:0] out_k0, out_k1, out_k2;
  logic [3:0]  out_nbytes;
  logic [7:0]  out_key_length;

  memcache_key_packer dut (
    .CLK(CLK), .RST(RST), .start(start), .key_length(key_length), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_k0(out_k0), .out_k1(out_k1), .out_k2(out_k2), .out_nbytes(out_nbytes),
    .out_first(out_first), .out_last(out_last), .out_key_length(out_key_length), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] k0, k1, k2;
    logic [3:0]  nb;
    logic        f, l;
    logic [7:0]  kl;
  } blk_t;

  blk_t       rx_q[$], exp_q[$];
  logic [7:0] key_mem[256];
  int errors = 0, checks = 0;
  int byte_idx, bubbles, stab_err, idx_stall_end, lat_cyc, first_ov_cyc, err_pulses, busy_low;
  bit timed_out;

  // Model: split the key into consecutive 12-byte chunks, byte p of a chunk at word p/4, big-endian.
  task automatic build_expected(input int len);
    int nb;
    exp_q.delete();
    nb = (len == 0) ? 1 : (len + 11) / 12;
    for (int b = 0; b < nb; b++) begin
      blk_t e;
      int lo, hi;
      e  = '0;
      lo = b * 12;
      hi = (lo + 12 < len) ? lo + 12 : len;
      for (int i = lo; i < hi; i++) begin
        int p;
        p = i - lo;
        case (p / 4)
          0: e.k0 = e.k0 | (32'(key_mem[i]) << (24 - 8 * (p % 4)));
          1: e.k1 = e.k1 | (32'(key_mem[i]) << (24 - 8 * (p % 4)));
          default: e.k2 = e.k2 | (32'(key_mem[i]) << (24 - 8 * (p % 4)));
        endcase
      end
      e.nb = 4'(hi - lo);
      e.f  = (b == 0);
      e.l  = (b == nb - 1);
      e.kl = 8'(len);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_key(input int len, input bit rnd);
    for (int i = 0; i < len; i++) key_mem[i] = rnd ? 8'($urandom) : 8'(8'h61 + i);
  endtask

  // Runs one key through the DUT, collecting accepted blocks into rx_q.
  task automatic drive_key(input int len, input int stall_len, input bit rv, input bit rr, input bit glitch);
    int   stall_cnt;
    bit   done, held;
    blk_t prev, cur;
    rx_q.delete();
    byte_idx = 0; bubbles = 0; stab_err = 0; idx_stall_end = -1; lat_cyc = -1;
    first_ov_cyc = -1; err_pulses = 0; busy_low = 0; timed_out = 0;
    stall_cnt = 0; done = 0; held = 0; prev = '0;
    @(negedge CLK);
    start = 1'b1; key_length = 8'(len); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      cur = {out_k0, out_k1, out_k2, out_nbytes, out_first, out_last, out_key_length};
      if (held && cur !== prev) stab_err++;
      if (err) err_pulses++;
      if (!busy) busy_low++;
      start = glitch && (c == 3);
      key_length = glitch && (c == 3) ? 8'd7 : 8'(len);
      out_ready = rr ? ($urandom_range(3) != 0) : 1'b1;
      if (out_valid && rx_q.size() == 0 && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == stall_len) idx_stall_end = byte_idx;
      end
      in_valid = (byte_idx < len) && (rv ? ($urandom_range(2) != 0) : 1'b1);
      in_data  = in_valid ? key_mem[byte_idx] : 8'($urandom);
      #1;
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = c;
      if (in_valid && !in_ready) bubbles++;
      if (in_valid && in_ready) begin
        if (byte_idx == 11) lat_cyc = c;
        byte_idx++;
      end
      if (out_valid && out_ready) begin
        rx_q.push_back(cur);
        if (out_last) done = 1;
      end
      held = out_valid && !out_ready;
      prev = cur;
      @(negedge CLK);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    timed_out = !done;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b0; key_length = 8'd0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, in_ready, out_valid, out_first, out_last, err, out_k0, out_k1, out_k2, out_nbytes, out_key_length} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b ir=%b ov=%b k=%h_%h_%h nb=%0d kl=%0d expected all zero",
               busy, in_ready, out_valid, out_k0, out_k1, out_k2, out_nbytes, out_key_length);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_key13;
    fill_key(13, 0);
    drive_key(13, 0, 0, 0, 0);
    build_expected(13);
    checks++;
    if (timed_out || rx_q.size() != 2) begin
      errors++; $display("FAIL k13_count got %0d blocks (timeout=%0d) expected 2", rx_q.size(), timed_out);
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL k13_blk%0d got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rx_q.size() < 1 || rx_q[0].k0 !== 32'h61626364 || rx_q[0].k2 !== 32'h696A6B6C) begin
      errors++; $display("FAIL k13_lanes got %h expected k0=61626364 k2=696a6b6c", rx_q.size() ? rx_q[0] : '0);
    end
    checks++;
    if (first_ov_cyc !== lat_cyc + 1) begin
      errors++; $display("FAIL k13_latency got out_valid cycle %0d expected %0d", first_ov_cyc, lat_cyc + 1);
    end
  endtask

  task automatic test_zero_len;
    drive_key(0, 0, 0, 0, 0);
    build_expected(0);
    checks++;
    if (timed_out || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL zero_block got %0d blocks first=%h expected 1 block %h", rx_q.size(), rx_q.size() ? rx_q[0] : '0, exp_q[0]);
    end
    checks++;
    if (busy !== 1'b0 || busy_low != 0) begin
      errors++; $display("FAIL zero_busy got busy=%b low_while_active=%0d expected 0/0", busy, busy_low);
    end
  endtask

  task automatic test_exact12;
    fill_key(12, 0);
    drive_key(12, 0, 0, 0, 0);
    build_expected(12);
    repeat (3) @(negedge CLK);
    checks++;
    if (timed_out || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || out_valid !== 1'b0) begin
      errors++; $display("FAIL exact12 got %0d blocks first=%h ov_after=%b expected 1 block %h", rx_q.size(), rx_q.size() ? rx_q[0] : '0, out_valid, exp_q[0]);
    end
  endtask

  task automatic test_stall30;
    fill_key(30, 1);
    drive_key(30, 20, 0, 0, 1);
    build_expected(30);
    checks++;
    if (timed_out || rx_q.size() != 3) begin
      errors++; $display("FAIL stall_count got %0d blocks expected 3", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_blk%0d got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL stall_hold got %0d changes expected 0", stab_err);
    end
    checks++;
    if (idx_stall_end != 24) begin
      errors++; $display("FAIL stall_backpressure got %0d bytes taken expected 24", idx_stall_end);
    end
  endtask

  task automatic test_back_to_back;
    fill_key(36, 1);
    drive_key(36, 0, 0, 0, 0);
    build_expected(36);
    checks++;
    if (timed_out || bubbles != 0 || rx_q.size() != 3) begin
      errors++; $display("FAIL b2b got bubbles=%0d blocks=%0d expected 0 and 3", bubbles, rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_blk%0d got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_idle_bytes;
    int taken;
    taken = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_data = 8'($urandom);
      #1;
      if (in_ready) taken++;
    end
    in_valid = 1'b0;
    checks++;
    if (taken != 0) begin
      errors++; $display("FAIL idle_in_ready got %0d accepted expected 0", taken);
    end
    fill_key(5, 1);
    drive_key(5, 0, 0, 0, 0);
    build_expected(5);
    checks++;
    if (timed_out || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL idle_key got %h expected %h", rx_q.size() ? rx_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int len;
      len = (t == 0) ? 24 : $urandom_range(255);
      fill_key(len, 1);
      drive_key(len, 0, 1'($urandom), 1'($urandom), 0);
      build_expected(len);
      checks++;
      if (timed_out || rx_q.size() != exp_q.size() || stab_err != 0) begin
        errors++; $display("FAIL rand%0d_len%0d got %0d blocks hold_changes=%0d expected %0d blocks 0 changes", t, len, rx_q.size(), stab_err, exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_blk%0d got %h expected %h", t, i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid;
    int taken;
    fill_key(20, 1);
    @(negedge CLK);
    start = 1'b1; key_length = 8'd20; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    taken = 0;
    for (int c = 0; c < 50 && taken < 7; c++) begin
      in_valid = 1'b1; in_data = key_mem[taken];
      #1;
      if (in_ready) taken++;
      @(negedge CLK);
    end
    in_valid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({busy, in_ready, out_valid, out_first, out_last, err, out_k0, out_k1, out_k2, out_nbytes, out_key_length} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got busy=%b ov=%b kl=%0d expected all zero", busy, out_valid, out_key_length);
    end
    RST = 1'b0;
    key_mem[0] = 8'h77; key_mem[1] = 8'h78; key_mem[2] = 8'h79; key_mem[3] = 8'h7A;
    drive_key(4, 0, 0, 0, 0);
    build_expected(4);
    checks++;
    if (timed_out || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || rx_q[0].k0 !== 32'h7778797A) begin
      errors++; $display("FAIL rst_mid_wxyz got %h expected %h", rx_q.size() ? rx_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_len_check;
`ifdef KEY_PACKER_LEN_CHECK_EN
    int ov_seen;
    @(negedge CLK);
    start = 1'b1; key_length = 8'd251; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lencheck_pulse got err=%b busy=%b expected 1/0", err, busy);
    end
    ov_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (out_valid || busy || err) ov_seen++;
    end
    checks++;
    if (ov_seen != 0) begin
      errors++; $display("FAIL lencheck_quiet got %0d active cycles expected 0", ov_seen);
    end
    fill_key(250, 1);
    drive_key(250, 0, 0, 0, 0);
    build_expected(250);
`else
    fill_key(251, 1);
    drive_key(251, 0, 0, 0, 0);
    build_expected(251);
    checks++;
    if (err_pulses != 0) begin
      errors++; $display("FAIL nocheck_err got %0d pulses expected 0", err_pulses);
    end
`endif
    checks++;
    if (timed_out || rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL long_count got %0d blocks expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL long_blk%0d got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key13();
    test_zero_len();
    test_exact12();
    test_stall30();
    test_back_to_back();
    test_idle_bytes();
    test_rst_mid();
    test_len_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
